param_counter: RTL and testbench
================================

Name: param_counter

Overview:
- Parametrised successor to the team's fixed 3-bit free-running counter.
- Features: configurable width, modulus and clock-enable prescaler; runtime mode select (hold/up/down/bounce); synchronous parallel load; registered terminal-count pulse.
- Used as the timebase/sequencer primitive in lab designs (display scanning, stopwatch digits, LED sweeps).

Parameters:
- WIDTH, 3, counter bit width.
- MAX_VAL, 7, terminal value; count range 0..MAX_VAL. Requires 1 <= MAX_VAL <= 2^WIDTH-1.
- PRESCALE, 1, enabled clock cycles per count step. Requires PRESCALE >= 1; 1 means step every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable for prescaler and counting.
- mode  input  2  00 hold, 01 up, 10 down, 11 bounce.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- dir  output  1  current direction, 0 up / 1 down, registered.

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a clk edge with rst=1, out=0, tc=0, dir=0 and the prescaler count is 0. This holds regardless of load, en or mode.
- Priority per edge: rst > load > step.
- load=1 (rst=0):
  - out <= min(load_val, MAX_VAL).
  - Prescaler count cleared; tc <= 0; dir unchanged.
  - en is ignored for that cycle.
- Prescaler:
  - Counts 0..PRESCALE-1 on cycles with en=1 (and no rst/load), then wraps.
  - tick = en && (pcount == PRESCALE-1).
  - en=0 freezes pcount.
  - The prescaler runs in every mode, including hold.
- Step on tick, by mode:
  - Hold: out unchanged.
  - Up: dir <= 0. out <= out+1, or 0 when out==MAX_VAL (wrap).
  - Down: dir <= 1. out <= out-1, or MAX_VAL when out==0 (wrap).
  - Bounce: effective direction is down if out==MAX_VAL, up if out==0, otherwise dir. out moves one step in the effective direction. When the new value equals MAX_VAL, dir <= 1; when it equals 0, dir <= 0.
- tc:
  - Asserted for exactly one cycle, in the same cycle out first shows the terminal value reached by a step.
  - Up: wrap to 0. Down: wrap to MAX_VAL. Bounce: arrival at MAX_VAL or at 0.
  - 0 on all non-tick cycles, on hold steps, and after load.
- Mode change takes effect at the next tick. dir in bounce mode continues from its current value.
- Arithmetic stays in WIDTH bits; out > MAX_VAL is unreachable.
- Latency: out/tc/dir update one edge after the tick or load condition.

Decomposition:
- Shared package counter_pkg:
  - Mode localparams MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_BOUNCE=2'b11.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module clk_prescaler (parameter PRESCALE; ports clk, rst, en, clr, tick) generates tick.
- The counter core and the next-state case on mode live in param_counter.

Test Plan:
- Defaults, rst=1 for 10 cycles then 0, en=1, mode=up → out 0,1,…,7,0,1. tc=1 only on the cycle out returns to 0. dir=0.
- mode=down from out=0 → out 7 (tc=1), 6,5,…,0, 7 (tc=1). dir=1.
- MAX_VAL=5, mode=bounce from reset → out 0,1,2,3,4,5(tc),4,3,2,1,0(tc),1. dir goes 1 at 5 and 0 at 0.
- PRESCALE=4, mode=up, en=1 → out increments every 4th cycle. Drop en for 3 cycles mid-period → the step is delayed by exactly 3 cycles.
- WIDTH=4, MAX_VAL=7:
  - load=1, load_val=9 → out=7, tc=0.
  - load on the same cycle as a tick → load wins, no step.
  - rst=1 together with load=1 → out=0.
- Bounce, out=3, dir=1, rst pulsed for 1 cycle → out=0, dir=0, tc=0. Counting resumes upward after PRESCALE enabled cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode and direction encodings for the counter slice
package counter_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/clk_prescaler.sv
// rtl/clk_prescaler.sv - enable-gated modulo-PRESCALE divider producing a step tick
module clk_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcount_q;
    logic [PW-1:0] pcount_d;

    // clr blocks the tick so a load never coincides with a step
    assign tick = en && !clr && (pcount_q == LAST);

    always_comb begin
        pcount_d = pcount_q;
        if (clr) begin
            pcount_d = '0;
        end else if (en) begin
            pcount_d = (pcount_q == LAST) ? '0 : pcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// rtl/param_counter.sv - modulo counter with hold/up/down/bounce modes, load and tc pulse
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 7,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             dir
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    logic             tick;
    logic             bounce_down;
    logic [WIDTH-1:0] bounce_nxt;

    clk_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    // At either end the bounce direction is forced; in between it follows dir_q
    always_comb begin
        bounce_down = dir_q;
        if (out_q == MAX) begin
            bounce_down = DIR_DOWN;
        end else if (out_q == '0) begin
            bounce_down = DIR_UP;
        end
        bounce_nxt = bounce_down ? out_q - 1'b1 : out_q + 1'b1;
    end

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (load) begin
            out_d = (load_val > MAX) ? MAX : load_val;
        end else if (tick) begin
            case (mode)
                MODE_UP: begin
                    dir_d = DIR_UP;
                    if (out_q == MAX) begin
                        out_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (out_q == '0) begin
                        out_d = MAX;
                        tc_d  = 1'b1;
                    end else begin
                        out_d = out_q - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    out_d = bounce_nxt;
                    if (bounce_nxt == MAX) begin
                        dir_d = DIR_DOWN;
                        tc_d  = 1'b1;
                    end else if (bounce_nxt == '0) begin
                        dir_d = DIR_UP;
                        tc_d  = 1'b1;
                    end
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            dir_q <= DIR_UP;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            dir_q <= dir_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign dir = dir_q;

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - randomized and directed checks of two param_counter configurations
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [2:0] out_a;
    logic [3:0] out_b;
    logic       tc_a, tc_b, dir_a, dir_b;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: index 0 = default build, index 1 = WIDTH 4 / MAX 5 / PRESCALE 4
    int mx[2] = '{7, 5};
    int ps[2] = '{1, 4};
    int m_out[2];
    int m_tc[2];
    int m_dir[2];
    int m_pc[2];

    always #5 clk = ~clk;

    param_counter u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_val(load_val[2:0]), .out(out_a), .tc(tc_a), .dir(dir_a)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(5), .PRESCALE(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(out_b), .tc(tc_b), .dir(dir_b)
    );

    task automatic model_edge(input bit r, input bit e, input bit l, input int m, input int lv);
        for (int k = 0; k < 2; k++) begin
            int lvk;
            bit tk;
            int down;
            lvk = (k == 0) ? (lv % 8) : lv;
            if (r) begin
                m_out[k] = 0; m_tc[k] = 0; m_dir[k] = 0; m_pc[k] = 0;
            end else if (l) begin
                m_out[k] = (lvk < mx[k]) ? lvk : mx[k];
                m_pc[k] = 0; m_tc[k] = 0;
            end else begin
                tk = e && (m_pc[k] == ps[k] - 1);
                if (e) m_pc[k] = (m_pc[k] + 1) % ps[k];
                m_tc[k] = 0;
                if (tk) begin
                    if (m == 1) begin
                        m_dir[k] = 0;
                        m_out[k] = (m_out[k] + 1) % (mx[k] + 1);
                        m_tc[k] = (m_out[k] == 0);
                    end else if (m == 2) begin
                        m_dir[k] = 1;
                        m_out[k] = (m_out[k] + mx[k]) % (mx[k] + 1);
                        m_tc[k] = (m_out[k] == mx[k]);
                    end else if (m == 3) begin
                        down = (m_out[k] == mx[k]) ? 1 : (m_out[k] == 0) ? 0 : m_dir[k];
                        m_out[k] = down ? m_out[k] - 1 : m_out[k] + 1;
                        if (m_out[k] == mx[k]) begin m_dir[k] = 1; m_tc[k] = 1; end
                        if (m_out[k] == 0) begin m_dir[k] = 0; m_tc[k] = 1; end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit l, input logic [1:0] m, input logic [3:0] lv);
        @(negedge clk);
        rst = r; en = e; load = l; mode = m; load_val = lv;
        @(posedge clk);
        model_edge(r, e, l, int'(m), int'(lv));
        #1;
    endtask

    function automatic logic [10:0] expv();
        logic [3:0] ob;
        logic [2:0] oa;
        ob = 4'(m_out[1]);
        oa = 3'(m_out[0]);
        return {ob, oa, m_tc[1][0], m_tc[0][0], m_dir[1][0], m_dir[0][0]};
    endfunction

    function automatic logic [10:0] obsv();
        return {out_b, out_a, tc_b, tc_a, dir_b, dir_a};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 2'b01, 4'hF);
            n_checks++;
            if (obsv() !== 11'd0) begin
                n_errors++;
                $display("FAIL reset cyc %0d: got %h want 000", i, obsv());
            end
        end
    endtask

    task automatic test_up();
        int e;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b01, 4'd0);
            e = (i + 1) % 8;
            n_checks++;
            if ({out_a, tc_a, dir_a} !== {3'(e), (e == 0), 1'b0}) begin
                n_errors++;
                $display("FAIL up cyc %0d: got out=%0d tc=%0d dir=%0d want out=%0d tc=%0d dir=0",
                         i, out_a, tc_a, dir_a, e, (e == 0));
            end
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL up_model cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_down();
        int e;
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
            e = (8 - ((i + 1) % 8)) % 8;
            n_checks++;
            if ({out_a, tc_a, dir_a} !== {3'(e), (e == 7), 1'b1}) begin
                n_errors++;
                $display("FAIL down cyc %0d: got out=%0d tc=%0d dir=%0d want out=%0d tc=%0d dir=1",
                         i, out_a, tc_a, dir_a, e, (e == 7));
            end
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL down_model cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_bounce();
        int seq[12] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};
        int step_no;
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        step_no = 0;
        // dut_b (MAX 5) steps every 4th enabled cycle; check each step against the fixed bounce path
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL bounce_model cyc %0d: got %h want %h", i, obsv(), expv());
            end
            if (i % 4 == 3) begin
                n_checks++;
                if ({out_b, tc_b} !== {4'(seq[step_no]), (seq[step_no] == 5 || seq[step_no] == 0)}) begin
                    n_errors++;
                    $display("FAIL bounce step %0d: got out=%0d tc=%0d want out=%0d", step_no, out_b, tc_b, seq[step_no]);
                end
                step_no++;
            end
        end
    endtask

    task automatic test_prescale();
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, !(i >= 5 && i < 8), 1'b0, 2'b01, 4'd0);
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL prescale cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
        // 14 cycles with 3 disabled leaves 11 enabled: two steps of four
        n_checks++;
        if (out_b !== 4'd2) begin
            n_errors++;
            $display("FAIL prescale_count: got out_b=%0d want 2", out_b);
        end
    endtask

    task automatic test_load();
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 4'd9);
        n_checks++;
        if ({out_b, tc_b, out_a, tc_a} !== {4'd5, 1'b0, 3'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL load_clamp: got b=%0d/%0d a=%0d/%0d want b=5/0 a=1/0", out_b, tc_b, out_a, tc_a);
        end
        cycle(1'b0, 1'b1, 1'b1, 2'b01, 4'd7);
        n_checks++;
        if ({out_a, tc_a} !== {3'd7, 1'b0}) begin
            n_errors++;
            $display("FAIL load_vs_tick: got out=%0d tc=%0d want 7/0", out_a, tc_a);
        end
        cycle(1'b1, 1'b1, 1'b1, 2'b01, 4'd3);
        n_checks++;
        if (obsv() !== 11'd0) begin
            n_errors++;
            $display("FAIL rst_over_load: got %h want 000", obsv());
        end
    endtask

    task automatic test_rst_midbounce();
        int guard;
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        guard = 0;
        while (!(out_a == 3'd3 && dir_a == 1'b1) && guard < 40) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
            guard++;
        end
        n_checks++;
        if (guard >= 40) begin
            n_errors++;
            $display("FAIL midbounce_reach: got out=%0d dir=%0d want out=3 dir=1", out_a, dir_a);
        end
        cycle(1'b1, 1'b1, 1'b0, 2'b11, 4'd0);
        n_checks++;
        if (obsv() !== 11'd0) begin
            n_errors++;
            $display("FAIL midbounce_rst: got %h want 000", obsv());
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL midbounce_resume cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_random();
        bit r, e, l;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            cycle(r, e, l, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            n_checks++;
            if (obsv() !== expv()) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0; m_tc[k] = 0; m_dir[k] = 0; m_pc[k] = 0;
        end
        test_reset();
        test_up();
        test_down();
        test_bounce();
        test_prescale();
        test_load();
        test_rst_midbounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
